// File: rtl/tiger_ckpt_ctrl.sv
// tiger_ckpt_ctrl: multi-slot checkpoint/rollback controller for the tiger core.
// A checkpoint stalls the pipeline and waits for it to drain. It then copies the PC and
// NUM_REGS registers into the next shadow slot, and commits that slot in one cycle.
// A restore writes the newest committed slot back into the register file and returns its PC.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   ckpt_req, restore_req       requests, sampled in IDLE only (restore wins)
//   poweroff                    aborts any operation, gates strobes/pulses combinationally
//   pipe_empty, pc_in           drain handshake and PC to save
//   zstall, checkpointing       status levels
//   checkpointdone              1-cycle pulse on commit
//   restoredone, restore_fail   1-cycle pulse at end of restore (+ no-slot flag)
//   rf_addr, rf_rd_en, rf_rdata register file read port (rdata one cycle after rd_en)
//   rf_wr_en, rf_wdata          register file write port
//   pc_restore                  restored PC while restoredone=1 and restore_fail=0
//   valid_slots, cur_slot       committed slot map and newest committed slot
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation, pipeline running
// DRAIN   | checkpoint: wait for pipe_empty, then latch PC into target slot
// SAVE    | checkpoint: read regs 0..NUM_REGS-1, store each one cycle later
// COMMIT  | checkpoint: mark target slot valid and newest
// RESTORE | rollback: write regs 0..NUM_REGS-1 from newest slot
// DONE    | rollback: report PC or failure
module tiger_ckpt_ctrl #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int REGNUM_W  = 5,
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ckpt_req,
  input  logic                 restore_req,
  input  logic                 poweroff,
  input  logic                 pipe_empty,
  input  logic [DATA_W-1:0]    pc_in,
  output logic                 zstall,
  output logic                 checkpointing,
  output logic                 checkpointdone,
  output logic                 restoredone,
  output logic                 restore_fail,
  output logic [REGNUM_W-1:0]  rf_addr,
  output logic                 rf_rd_en,
  input  logic [DATA_W-1:0]    rf_rdata,
  output logic                 rf_wr_en,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [DATA_W-1:0]    pc_restore,
  output logic [NUM_SLOTS-1:0] valid_slots,
  output logic [SLOT_W-1:0]    cur_slot
);

  // One extra counter bit so SAVE can reach k = NUM_REGS (the final store-only cycle).
  localparam int CNT_W = REGNUM_W + 1;
  localparam logic [CNT_W-1:0]  SAVE_LAST    = CNT_W'(NUM_REGS);
  localparam logic [CNT_W-1:0]  RESTORE_LAST = CNT_W'(NUM_REGS - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX     = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_RESTORE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SLOT_W-1:0]      tgt_q, tgt_d;
  logic                   fail_q, fail_d;
  logic [NUM_SLOTS-1:0]   valid_q, valid_d;
  logic [SLOT_W-1:0]      cur_q, cur_d;

  logic                   pc_we;
  logic                   sv_we;
  logic [REGNUM_W-1:0]    sv_idx;
  logic [SLOT_W-1:0]      next_slot;

  // Shadow banks: plain storage, no reset (contents are meaningless until committed).
  logic [DATA_W-1:0] shadow_mem [NUM_SLOTS][NUM_REGS];
  logic [DATA_W-1:0] pc_mem     [NUM_SLOTS];

  always_comb begin
    if (valid_q == '0) begin
      next_slot = '0;
    end else if (cur_q == SLOT_MAX) begin
      next_slot = '0;
    end else begin
      next_slot = cur_q + 1'b1;
    end
  end

  // Read data for address k-1 arrives while the counter is at k.
  assign sv_idx = REGNUM_W'(cnt_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    fail_d  = fail_q;
    valid_d = valid_q;
    cur_d   = cur_q;
    pc_we   = 1'b0;
    sv_we   = 1'b0;
    if (poweroff) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          fail_d = 1'b0;
          if (restore_req) begin
            if (valid_q != '0) begin
              state_d = ST_RESTORE;
            end else begin
              state_d = ST_DONE;
              fail_d  = 1'b1;
            end
          end else if (ckpt_req) begin
            state_d = ST_DRAIN;
            tgt_d   = next_slot;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            // Invalidate the target before overwriting it so an aborted save can never
            // leave a half-written slot marked valid.
            pc_we            = 1'b1;
            valid_d[tgt_q]   = 1'b0;
            cnt_d            = '0;
            state_d          = ST_SAVE;
          end
        end
        ST_SAVE: begin
          sv_we = (cnt_q != '0);
          if (cnt_q == SAVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          valid_d[tgt_q] = 1'b1;
          cur_d          = tgt_q;
          state_d        = ST_IDLE;
        end
        ST_RESTORE: begin
          if (cnt_q == RESTORE_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      fail_q  <= 1'b0;
      valid_q <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      fail_q  <= fail_d;
      valid_q <= valid_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pc_we) begin
      pc_mem[tgt_q] <= pc_in;
    end
    if (sv_we) begin
      shadow_mem[tgt_q][sv_idx] <= rf_rdata;
    end
  end

  // Strobes and pulses decode from registered state; poweroff kills them in the same cycle.
  assign zstall         = (state_q != ST_IDLE);
  assign checkpointing  = (state_q == ST_DRAIN) || (state_q == ST_SAVE) || (state_q == ST_COMMIT);
  assign checkpointdone = (state_q == ST_COMMIT) && !poweroff;
  assign rf_rd_en       = (state_q == ST_SAVE) && (cnt_q < SAVE_LAST) && !poweroff;
  assign rf_wr_en       = (state_q == ST_RESTORE) && !poweroff;
  assign restoredone    = (state_q == ST_DONE) && !poweroff;
  assign restore_fail   = restoredone && fail_q;
  assign rf_addr        = (rf_rd_en || rf_wr_en) ? cnt_q[REGNUM_W-1:0] : '0;
  assign rf_wdata       = rf_wr_en ? shadow_mem[cur_q][cnt_q[REGNUM_W-1:0]] : '0;
  assign pc_restore     = (restoredone && !fail_q) ? pc_mem[cur_q] : '0;
  assign valid_slots    = valid_q;
  assign cur_slot       = cur_q;

endmodule

// File: tb/tb_tiger_ckpt_ctrl.sv
module tb_tiger_ckpt_ctrl;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int RW = 5;
  localparam int NS = 2;
  localparam int SW = 1;

  logic clk = 1'b0;
  logic reset, ckpt_req, restore_req, poweroff, pipe_empty;
  logic [DW-1:0] pc_in, rf_rdata, rf_wdata, pc_restore;
  logic zstall, checkpointing, checkpointdone, restoredone, restore_fail, rf_rd_en, rf_wr_en;
  logic [RW-1:0] rf_addr;
  logic [NS-1:0] valid_slots;
  logic [SW-1:0] cur_slot;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tiger_ckpt_ctrl #(.DATA_W(DW), .NUM_REGS(NR), .REGNUM_W(RW), .NUM_SLOTS(NS), .SLOT_W(SW)) dut (
    .clk(clk), .reset(reset), .ckpt_req(ckpt_req), .restore_req(restore_req), .poweroff(poweroff),
    .pipe_empty(pipe_empty), .pc_in(pc_in), .zstall(zstall), .checkpointing(checkpointing),
    .checkpointdone(checkpointdone), .restoredone(restoredone), .restore_fail(restore_fail),
    .rf_addr(rf_addr), .rf_rd_en(rf_rd_en), .rf_rdata(rf_rdata), .rf_wr_en(rf_wr_en),
    .rf_wdata(rf_wdata), .pc_restore(pc_restore), .valid_slots(valid_slots), .cur_slot(cur_slot)
  );

  // Register file model: registered read, write on strobe, bulk load from seed_val.
  logic [DW-1:0] regs [NR];
  logic [DW-1:0] seed_val [NR];
  logic seed_go;
  always @(posedge clk) begin
    if (seed_go) begin
      for (int i = 0; i < NR; i++) regs[i] <= seed_val[i];
    end else if (rf_wr_en) begin
      regs[rf_addr] <= rf_wdata;
    end
    if (rf_rd_en) rf_rdata <= regs[rf_addr];
  end

  // Strobe monitor: cumulative counts; a run of consecutive strobes must address 0,1,2,...
  int rd_cnt = 0, wr_cnt = 0, rd_bad = 0, wr_bad = 0, both_cnt = 0, cd_cnt = 0, rdn_cnt = 0;
  int rd_run = 0, wr_run = 0;
  always @(negedge clk) begin
    if (rf_rd_en) begin
      if (int'(rf_addr) != rd_run) rd_bad++;
      rd_run++; rd_cnt++;
    end else rd_run = 0;
    if (rf_wr_en) begin
      if (int'(rf_addr) != wr_run) wr_bad++;
      wr_run++; wr_cnt++;
    end else wr_run = 0;
    if (rf_rd_en && rf_wr_en) both_cnt++;
    if (checkpointdone) cd_cnt++;
    if (restoredone) rdn_cnt++;
  end
  int b_rd, b_wr, b_rdbad, b_wrbad, b_cd, b_rdn;

  // Reference model: committed slots as plain arrays.
  logic [DW-1:0] m_regs [NS][NR];
  logic [DW-1:0] m_pc [NS];
  int m_valid, m_cur;

  function automatic int model_tgt();
    return (m_valid == 0) ? 0 : (m_cur + 1) % NS;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    b_rd = rd_cnt; b_wr = wr_cnt; b_rdbad = rd_bad; b_wrbad = wr_bad; b_cd = cd_cnt; b_rdn = rdn_cnt;
  endtask

  task automatic load_random_regs();
    for (int i = 0; i < NR; i++) seed_val[i] = $urandom();
    seed_go = 1'b1; tick(); seed_go = 1'b0;
  endtask

  task automatic snap_slot(input int s, input logic [DW-1:0] pc);
    for (int i = 0; i < NR; i++) m_regs[s][i] = seed_val[i];
    m_pc[s] = pc;
  endtask

  function automatic int regs_mismatch(input int s);
    int e = 0;
    for (int i = 0; i < NR; i++) if (regs[i] !== m_regs[s][i]) e++;
    return e;
  endfunction

  // Checkpoint driver. Request in cycle 0; pipe_empty rises in cycle 1+extra; poweroff during
  // cycle abort_at (if >0); both requests re-poked during cycle poke_at (if >0).
  task automatic run_ckpt(input logic [DW-1:0] pc, input int extra, input int abort_at, input int poke_at,
                          output int lat, output bit done_seen, output bit gate_ok);
    clr_mon();
    pc_in = pc; pipe_empty = (extra == 0); ckpt_req = 1'b1;
    lat = 0; done_seen = 1'b0; gate_ok = 1'b1;
    while (!done_seen && lat < 200) begin
      tick(); ckpt_req = 1'b0; restore_req = 1'b0; lat++;
      if (lat == 1 + extra) pipe_empty = 1'b1;
      if (lat == poke_at) begin ckpt_req = 1'b1; restore_req = 1'b1; end
      if (lat == abort_at) begin
        poweroff = 1'b1; #1;
        gate_ok = !rf_rd_en && !checkpointdone;
        tick(); poweroff = 1'b0;
        break;
      end
      if (checkpointdone) done_seen = 1'b1;
    end
    tick();
    pipe_empty = 1'b1;
  endtask

  task automatic run_restore(input int abort_at, output int lat, output bit seen,
                             output logic [DW-1:0] pc, output logic fail, output bit gate_ok);
    clr_mon();
    restore_req = 1'b1; lat = 0; seen = 1'b0; pc = '0; fail = 1'b0; gate_ok = 1'b1;
    while (!seen && lat < 200) begin
      tick(); restore_req = 1'b0; ckpt_req = 1'b0; lat++;
      if (lat == abort_at) begin
        poweroff = 1'b1; #1;
        gate_ok = !rf_wr_en && !restoredone;
        tick(); poweroff = 1'b0;
        break;
      end
      if (restoredone) begin seen = 1'b1; pc = pc_restore; fail = restore_fail; end
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({zstall, checkpointing, checkpointdone, restoredone, restore_fail, rf_rd_en, rf_wr_en,
         rf_addr, rf_wdata, pc_restore, valid_slots, cur_slot} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: outputs not all zero during reset");
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (zstall !== 1'b0 || valid_slots !== '0 || cur_slot !== '0) begin
      n_fail++; $display("FAIL reset_release: zstall=%0b valid=%b cur=%0d, expected 0/00/0", zstall, valid_slots, cur_slot);
    end
  endtask

  task automatic test_restore_empty();
    int lat; bit seen, g; logic [DW-1:0] pc; logic fail;
    run_restore(-1, lat, seen, pc, fail, g);
    n_checks++;
    if (!seen || lat != 1) begin n_fail++; $display("FAIL empty_restore_latency: got %0d (seen=%0b) expected 1", lat, seen); end
    n_checks++;
    if (fail !== 1'b1 || pc !== '0) begin n_fail++; $display("FAIL empty_restore_flags: fail=%0b pc=%h expected 1/0", fail, pc); end
    n_checks++;
    if (wr_cnt - b_wr != 0) begin n_fail++; $display("FAIL empty_restore_writes: got %0d expected 0", wr_cnt - b_wr); end
  endtask

  task automatic test_checkpoint();
    int lat, tgt; bit done, g;
    for (int i = 0; i < NR; i++) seed_val[i] = DW'(i * 3);
    seed_go = 1'b1; tick(); seed_go = 1'b0;
    tgt = model_tgt();
    run_ckpt(32'h400, 0, -1, -1, lat, done, g);
    snap_slot(tgt, 32'h400); m_valid |= (1 << tgt); m_cur = tgt;
    n_checks++;
    if (!done || lat != NR + 3) begin n_fail++; $display("FAIL ckpt_latency: got %0d expected %0d", lat, NR + 3); end
    n_checks++;
    if (valid_slots !== NS'(m_valid) || cur_slot !== SW'(m_cur)) begin
      n_fail++; $display("FAIL ckpt_slots: valid=%b cur=%0d expected %b/%0d", valid_slots, cur_slot, NS'(m_valid), m_cur);
    end
    n_checks++;
    if (rd_cnt - b_rd != NR || rd_bad != b_rdbad) begin
      n_fail++; $display("FAIL ckpt_reads: count=%0d bad_addr=%0d expected %0d/0", rd_cnt - b_rd, rd_bad - b_rdbad, NR);
    end
  endtask

  task automatic test_restore();
    int lat, e; bit seen, g; logic [DW-1:0] pc; logic fail;
    load_random_regs();
    run_restore(-1, lat, seen, pc, fail, g);
    n_checks++;
    if (!seen || lat != NR + 1 || fail !== 1'b0) begin
      n_fail++; $display("FAIL restore_done: lat=%0d seen=%0b fail=%0b expected %0d/1/0", lat, seen, fail, NR + 1);
    end
    n_checks++;
    if (pc !== m_pc[m_cur]) begin n_fail++; $display("FAIL restore_pc: got %h expected %h", pc, m_pc[m_cur]); end
    n_checks++;
    if (wr_cnt - b_wr != NR || wr_bad != b_wrbad) begin
      n_fail++; $display("FAIL restore_writes: count=%0d bad_addr=%0d expected %0d/0", wr_cnt - b_wr, wr_bad - b_wrbad, NR);
    end
    e = regs_mismatch(m_cur);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL restore_regs: %0d registers differ, expected 0", e); end
  endtask

  task automatic test_poweroff_save();
    int lat, tgt, e; bit done, g, seen; logic [DW-1:0] pc; logic fail;
    load_random_regs();
    tgt = model_tgt();
    run_ckpt(32'h800, 0, 2 + 10, -1, lat, done, g);
    m_valid &= ~(1 << tgt);
    n_checks++;
    if (done || !g) begin n_fail++; $display("FAIL abort_save_gate: done=%0b gated=%0b expected 0/1", done, g); end
    n_checks++;
    if (valid_slots !== NS'(m_valid) || cur_slot !== SW'(m_cur)) begin
      n_fail++; $display("FAIL abort_save_slots: valid=%b cur=%0d expected %b/%0d", valid_slots, cur_slot, NS'(m_valid), m_cur);
    end
    run_restore(-1, lat, seen, pc, fail, g);
    n_checks++;
    if (!seen || pc !== 32'h400 || fail !== 1'b0) begin
      n_fail++; $display("FAIL abort_save_restore_pc: got %h fail=%0b expected 400/0", pc, fail);
    end
    e = regs_mismatch(m_cur);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL abort_save_restore_regs: %0d registers differ, expected 0", e); end
  endtask

  task automatic test_priority();
    int lat, tgt, e; bit seen, g, done; logic [DW-1:0] pc; logic fail, pcn;
    load_random_regs();
    ckpt_req = 1'b1;
    run_restore(-1, lat, seen, pc, fail, g);
    n_checks++;
    if (!seen || lat != NR + 1 || cd_cnt != b_cd || rd_cnt != b_rd) begin
      n_fail++; $display("FAIL both_req_restore_wins: lat=%0d ckptdone=%0d reads=%0d expected %0d/0/0", lat, cd_cnt - b_cd, rd_cnt - b_rd, NR + 1);
    end
    e = regs_mismatch(m_cur);
    n_checks++;
    if (e != 0 || pc !== m_pc[m_cur]) begin n_fail++; $display("FAIL both_req_regs: %0d differ, pc=%h expected 0/%h", e, pc, m_pc[m_cur]); end
    load_random_regs();
    tgt = model_tgt();
    pc = $urandom();
    run_ckpt(pc, 0, -1, 12, lat, done, g);
    snap_slot(tgt, pc); m_valid |= (1 << tgt); m_cur = tgt;
    pcn = zstall;
    n_checks++;
    if (!done || lat != NR + 3 || cd_cnt - b_cd != 1 || rdn_cnt != b_rdn || wr_cnt != b_wr || pcn !== 1'b0) begin
      n_fail++; $display("FAIL req_in_save_ignored: lat=%0d ckptdone=%0d restoredone=%0d writes=%0d zstall=%0b expected %0d/1/0/0/0",
                         lat, cd_cnt - b_cd, rdn_cnt - b_rdn, wr_cnt - b_wr, pcn, NR + 3);
    end
    n_checks++;
    if (valid_slots !== NS'(m_valid) || cur_slot !== SW'(m_cur)) begin
      n_fail++; $display("FAIL priority_slots: valid=%b cur=%0d expected %b/%0d", valid_slots, cur_slot, NS'(m_valid), m_cur);
    end
  endtask

  task automatic test_drain();
    int n, tgt, bad; logic [DW-1:0] pc;
    load_random_regs();
    tgt = model_tgt(); pc = $urandom();
    clr_mon();
    pc_in = pc; pipe_empty = 1'b0; ckpt_req = 1'b1; n = 0; bad = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(); ckpt_req = 1'b0; n++;
      if (zstall !== 1'b1 || checkpointing !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || rd_cnt != b_rd) begin
      n_fail++; $display("FAIL drain_stall: bad_cycles=%0d reads=%0d expected 0/0", bad, rd_cnt - b_rd);
    end
    while (n < 200) begin
      tick(); n++;
      if (n == 6) pipe_empty = 1'b1;
      if (checkpointdone) break;
    end
    tick();
    snap_slot(tgt, pc); m_valid |= (1 << tgt); m_cur = tgt;
    n_checks++;
    if (n != NR + 3 + 5 || rd_cnt - b_rd != NR) begin
      n_fail++; $display("FAIL drain_latency: got %0d reads=%0d expected %0d/%0d", n, rd_cnt - b_rd, NR + 8, NR);
    end
    n_checks++;
    if (valid_slots !== NS'(m_valid) || cur_slot !== SW'(m_cur)) begin
      n_fail++; $display("FAIL drain_slots: valid=%b cur=%0d expected %b/%0d", valid_slots, cur_slot, NS'(m_valid), m_cur);
    end
  endtask

  task automatic test_random();
    int lat, tgt, e, ex, ab, act, bad; bit done, g, seen; logic [DW-1:0] pc, rpc; logic fail;
    for (int it = 0; it < 16; it++) begin
      act = $urandom_range(0, 3);
      if (act <= 1) begin
        load_random_regs();
        tgt = model_tgt(); pc = $urandom(); ex = $urandom_range(0, 4);
        ab = ($urandom_range(0, 2) == 0) ? 2 + ex + $urandom_range(0, NR + 1) : -1;
        run_ckpt(pc, ex, ab, -1, lat, done, g);
        if (ab < 0) begin
          snap_slot(tgt, pc); m_valid |= (1 << tgt); m_cur = tgt;
          n_checks++;
          if (!done || lat != NR + 3 + ex) begin n_fail++; $display("FAIL rnd_ckpt_latency: got %0d expected %0d", lat, NR + 3 + ex); end
        end else begin
          m_valid &= ~(1 << tgt);
          n_checks++;
          if (done || !g) begin n_fail++; $display("FAIL rnd_ckpt_abort: done=%0b gated=%0b expected 0/1 (abort cycle %0d)", done, g, ab); end
        end
        n_checks++;
        if (valid_slots !== NS'(m_valid) || cur_slot !== SW'(m_cur)) begin
          n_fail++; $display("FAIL rnd_ckpt_slots: valid=%b cur=%0d expected %b/%0d", valid_slots, cur_slot, NS'(m_valid), m_cur);
        end
      end else if (act == 2) begin
        load_random_regs();
        if (m_valid != 0 && $urandom_range(0, 1) == 1) begin
          ab = $urandom_range(1, NR + 1);
          run_restore(ab, lat, seen, rpc, fail, g);
          n_checks++;
          if (seen || !g) begin n_fail++; $display("FAIL rnd_restore_abort: done=%0b gated=%0b expected 0/1", seen, g); end
        end
        run_restore(-1, lat, seen, rpc, fail, g);
        n_checks++;
        if (m_valid == 0) begin
          if (!seen || lat != 1 || fail !== 1'b1 || rpc !== '0 || wr_cnt != b_wr) begin
            n_fail++; $display("FAIL rnd_restore_empty: lat=%0d fail=%0b pc=%h expected 1/1/0", lat, fail, rpc);
          end
        end else begin
          e = regs_mismatch(m_cur);
          if (!seen || lat != NR + 1 || fail !== 1'b0 || rpc !== m_pc[m_cur] || e != 0) begin
            n_fail++; $display("FAIL rnd_restore: lat=%0d fail=%0b pc=%h regs_diff=%0d expected %0d/0/%h/0", lat, fail, rpc, e, NR + 1, m_pc[m_cur]);
          end
        end
      end else begin
        clr_mon();
        poweroff = 1'b1; ckpt_req = 1'b1; restore_req = 1'b1; bad = 0;
        repeat (4) begin tick(); if (zstall !== 1'b0) bad++; end
        ckpt_req = 1'b0; restore_req = 1'b0; poweroff = 1'b0;
        tick();
        n_checks++;
        if (bad != 0 || rd_cnt != b_rd || wr_cnt != b_wr || cd_cnt != b_cd || rdn_cnt != b_rdn || valid_slots !== NS'(m_valid)) begin
          n_fail++; $display("FAIL poweroff_held: busy_cycles=%0d valid=%b expected 0/%b", bad, valid_slots, NS'(m_valid));
        end
      end
    end
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", both_cnt); end
  endtask

  task automatic test_async_reset();
    int lat, tgt; bit done, g, seen; logic [DW-1:0] pc; logic fail;
    load_random_regs();
    tgt = model_tgt();
    run_ckpt(32'hC00, 0, -1, -1, lat, done, g);
    snap_slot(tgt, 32'hC00); m_valid |= (1 << tgt); m_cur = tgt;
    restore_req = 1'b1; tick(); restore_req = 1'b0; tick(); tick();
    #2 reset = 1'b1; #1;
    m_valid = 0; m_cur = 0;
    n_checks++;
    if ({zstall, checkpointing, checkpointdone, restoredone, restore_fail, rf_rd_en, rf_wr_en,
         rf_addr, rf_wdata, pc_restore, valid_slots, cur_slot} !== '0) begin
      n_fail++; $display("FAIL async_reset_outputs: zstall=%0b wr=%0b valid=%b expected all zero", zstall, rf_wr_en, valid_slots);
    end
    tick(); tick(); reset = 1'b0; tick();
    run_restore(-1, lat, seen, pc, fail, g);
    n_checks++;
    if (!seen || fail !== 1'b1 || lat != 1) begin
      n_fail++; $display("FAIL async_reset_cold: seen=%0b fail=%0b lat=%0d expected 1/1/1", seen, fail, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ckpt_req = 1'b0; restore_req = 1'b0; poweroff = 1'b0; pipe_empty = 1'b1;
    pc_in = '0; seed_go = 1'b0; m_valid = 0; m_cur = 0;
    test_reset();
    test_restore_empty();
    test_checkpoint();
    test_restore();
    test_poweroff_save();
    test_priority();
    test_drain();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
